// File: rtl/mem_arb2_if.sv
// mem_arb2_if: bundle of the requester and memory-side signals of mem_arb2.
//   Requester N (N=0,1): reqN_i, weN_i, addrN_i, wdataN_i  -> arbiter
//                        ackN_o, errN_o, rdataN_o           <- arbiter
//   Memory side:         mem_addr_o, mem_we_o, mem_wdata_o  <- arbiter
//                        mem_rdata_i                        -> arbiter
// Signal suffixes are from the arbiter's point of view.
// Modport slave is the arbiter; modport master is the requesters plus memory.
interface mem_arb2_if;
    logic        req0_i;
    logic        we0_i;
    logic [31:0] addr0_i;
    logic [31:0] wdata0_i;
    logic        ack0_o;
    logic        err0_o;
    logic [31:0] rdata0_o;

    logic        req1_i;
    logic        we1_i;
    logic [31:0] addr1_i;
    logic [31:0] wdata1_i;
    logic        ack1_o;
    logic        err1_o;
    logic [31:0] rdata1_o;

    logic [29:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req0_i, we0_i, addr0_i, wdata0_i,
        input  req1_i, we1_i, addr1_i, wdata1_i,
        input  mem_rdata_i,
        output ack0_o, err0_o, rdata0_o,
        output ack1_o, err1_o, rdata1_o,
        output mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output req0_i, we0_i, addr0_i, wdata0_i,
        output req1_i, we1_i, addr1_i, wdata1_i,
        output mem_rdata_i,
        input  ack0_o, err0_o, rdata0_o,
        input  ack1_o, err1_o, rdata1_o,
        input  mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arb2.sv
// mem_arb2: two-requester round-robin arbiter in front of a single-port
// 32-bit word memory of MEM_WORDS words.
//   clk_i   : clock, all state updates on rising edge
//   rst_ni  : synchronous active-low reset
//   bus     : mem_arb2_if.slave (requester handshakes + memory port)
// Each transaction is IDLE -> ACCESS -> DONE -> IDLE (3 cycles).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; picks winner, latches its command
// ACCESS | drives memory with latched command; read data captured
// DONE   | one-cycle ack (+err if illegal) to the granted requester
module mem_arb2 #(
    parameter int MEM_WORDS = 4096
) (
    input logic        clk_i,
    input logic        rst_ni,
    mem_arb2_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e      state_q;
    logic        rr_q;       // index of the last granted requester
    logic        gnt_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        ack0_q, ack1_q;
    logic        err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        gnt_vld_d;
    logic        gnt_d;
    logic        legal;

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt_vld_d = bus.req0_i | bus.req1_i;
        gnt_d     = 1'b0;
        if (bus.req0_i && bus.req1_i) begin
            gnt_d = ~rr_q;
        end else if (bus.req1_i) begin
            gnt_d = 1'b1;
        end
    end

    assign legal = (addr_q[1:0] == 2'b00) && (addr_q[31:2] < MEM_WORDS_W);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_q     <= 1'b1;
            gnt_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        gnt_q   <= gnt_d;
                        rr_q    <= gnt_d;
                        addr_q  <= gnt_d ? bus.addr1_i  : bus.addr0_i;
                        we_q    <= gnt_d ? bus.we1_i    : bus.we0_i;
                        wdata_q <= gnt_d ? bus.wdata1_i : bus.wdata0_i;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (legal && !we_q) begin
                        if (gnt_q) rdata1_q <= bus.mem_rdata_i;
                        else       rdata0_q <= bus.mem_rdata_i;
                    end
                    ack0_q  <= ~gnt_q;
                    ack1_q  <= gnt_q;
                    err0_q  <= ~gnt_q & ~legal;
                    err1_q  <= gnt_q & ~legal;
                    state_q <= DONE;
                end
                DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    err0_q  <= 1'b0;
                    err1_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write strobe is combinational so a reset asserted during ACCESS
    // blocks the write on the same edge that would have committed it.
    assign bus.mem_we_o    = (state_q == ACCESS) && we_q && legal && rst_ni;
    assign bus.mem_addr_o  = addr_q[31:2];
    assign bus.mem_wdata_o = wdata_q;

    assign bus.ack0_o   = ack0_q;
    assign bus.ack1_o   = ack1_q;
    assign bus.err0_o   = err0_q;
    assign bus.err1_o   = err1_q;
    assign bus.rdata0_o = rdata0_q;
    assign bus.rdata1_o = rdata1_q;
endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 Parameter MEM_WORDS, default 4096: number of 32-bit words in the attached memory; legal word addresses are 0..MEM_WORDS-1.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  synchronous, active-low reset, sampled on rising edge of clk_i.
REQ-004 reqN_i  input  1  (N=0,1) requester N transaction request; held high until ackN_o.
REQ-005 weN_i  input  1  requester N write enable (1=write, 0=read); stable while reqN_i high.
REQ-006 addrN_i  input  32  requester N byte address; stable while reqN_i high.
REQ-007 wdataN_i  input  32  requester N write data; stable while reqN_i high.
REQ-008 ackN_o  output  1  one-cycle completion pulse to requester N.
REQ-009 errN_o  output  1  error flag, valid only with ackN_o.
REQ-010 rdataN_o  output  32  registered read data for requester N.
REQ-011 mem_addr_o  output  30  word address to memory (byte address bits [31:2]).
REQ-012 mem_we_o  output  1  memory write strobe, committed on the rising edge ending the cycle.
REQ-013 mem_wdata_o  output  32  memory write data.
REQ-014 mem_rdata_i  input  32  memory read data, combinational from mem_addr_o.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, ACCESS, DONE; every transaction takes exactly 3 cycles, IDLE -> ACCESS -> DONE -> IDLE.
REQ-016 IDLE: if no request, SHALL remain IDLE; if exactly one reqN_i high, SHALL grant N; if both high, SHALL grant the requester not granted last (round-robin pointer).
REQ-017 On grant, SHALL latch granted index, addr, we and wdata, update round-robin pointer to the granted index, and go to ACCESS.
REQ-018 ACCESS: mem_addr_o = latched addr[31:2]; mem_wdata_o = latched wdata; mem_we_o = latched we AND access legal AND rst_ni; then go to DONE.
REQ-019 Access is legal iff addr[1:0]==0 and addr[31:2] < MEM_WORDS.
REQ-020 ACCESS, legal read: SHALL capture mem_rdata_i into rdataN_o of the granted requester at the end of the ACCESS cycle.
REQ-021 DONE: ackN_o of the granted requester SHALL be 1 for exactly this cycle; errN_o = 1 iff access illegal; other requester's ack/err SHALL be 0.
REQ-022 Illegal access: no memory write, rdataN_o unchanged, acked with errN_o=1.
REQ-023 mem_we_o SHALL be 0 in IDLE and DONE; mem_addr_o and mem_wdata_o hold latched values outside ACCESS.
REQ-024 rdataN_o SHALL hold its value until the next legal read completes for requester N; writes and the other requester's transactions do not change it.
REQ-025 A request still high in the IDLE cycle after DONE is a new transaction; the requester SHALL drop reqN_i in that cycle if it has none.
REQ-026 Both requesters continuously requesting: grants SHALL alternate 0,1,0,1,...; no requester waits more than one transaction.
REQ-027 A request arriving while in ACCESS or DONE SHALL wait; it is considered only in IDLE.

Reset
REQ-028 rst_ni low at a rising edge SHALL force IDLE, round-robin pointer = 1 (requester 0 wins first tie), ack0_o=ack1_o=0, err0_o=err1_o=0, rdata0_o=rdata1_o=0, latched addr/wdata/we = 0.
REQ-029 rst_ni low during ACCESS SHALL suppress mem_we_o combinationally; the in-flight transaction is dropped without ack.

Verification
REQ-030 Single write then read: req0 write addr 0x10 data 0xDEADBEEF -> mem_we_o=1 for 1 cycle at word 4, ack0 3 cycles after req; then req0 read 0x10 -> rdata0_o=0xDEADBEEF with ack0, err0=0.
REQ-031 Tie after reset: req0 and req1 both raised same cycle -> requester 0 acked first, requester 1 acked 3 cycles later; continuous requests -> ack order 0,1,0,1.
REQ-032 Illegal: read addr 0x4002 (misaligned) and write addr 0x4000 (word 4096) -> err pulse with ack, mem_we_o stays 0, memory word 0 unchanged, rdata unchanged.
REQ-033 Isolation: req1 read of word holding 0x12345678 -> rdata1_o=0x12345678, rdata0_o unchanged.
REQ-034 Reset mid-op: rst_ni low in ACCESS of a write to 0x20 -> no write, no ack, state IDLE, all outputs at reset values next cycle.
